// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_ctrl_if
// Description : Signal bundle between the clock-set sequencer and the
//               surrounding digital-clock datapath (tick, buttons, terminal
//               counts in; counter enables and display controls out).
// Revision    : 1.0  initial release
// ============================================================================
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       sec_tc;
  logic       min_tc;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic [2:0] blink_sel;
  logic       blink_phase;

  // Datapath / stimulus side
  modport master (
    output tick_1hz, btn_mode, btn_up, sec_tc, min_tc,
    input  sec_en, min_en, hour_en, sec_clr, mode, blink_sel, blink_phase
  );

  // Sequencer side
  modport slave (
    input  tick_1hz, btn_mode, btn_up, sec_tc, min_tc,
    output sec_en, min_en, hour_en, sec_clr, mode, blink_sel, blink_phase
  );
endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_ctrl
// Description : Digital-clock sequencer. Cascades the 1 Hz tick into
//               sec/min/hour enables in RUN; in the SET modes it freezes
//               time, steps the selected field from the up button with
//               auto-repeat, drives field blink and times out back to RUN.
// Revision    : 1.0  initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int TIMEOUT_S  = 10,
  parameter int CNT_W      = 25
) (
  input logic             clk,
  input logic             clr,
  clock_set_ctrl_if.slave bus
);

  localparam int              TO_W    = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0] DLY_V   = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_V   = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_S - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  // Encoding doubles as the mode output value
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  state_t           state, state_next;
  logic [2:0]       mode_sync, up_sync;   // [0] first flop, [1] synced, [2] edge history
  logic [CNT_W-1:0] hold_cnt, hold_next;  // non-zero means an up press is armed for repeat
  logic             rep_first, first_next; // waiting for the initial (long) repeat delay
  logic [TO_W-1:0]  to_cnt, to_next;
  logic             sec_en_q, min_en_q, hour_en_q, sec_clr_q, phase_q;
  logic             sec_en_next, min_en_next, hour_en_next, sec_clr_next, phase_next;
  logic [2:0]       blink_q, blink_next;
  logic             mode_rise, up_rise, up_lvl, rep_step, step;

  assign mode_rise = mode_sync[1] & ~mode_sync[2];
  assign up_rise   = up_sync[1] & ~up_sync[2];
  assign up_lvl    = up_sync[1];

  // Bring the asynchronous buttons into the clk domain and keep one bit of history
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_sync <= 3'b000;
      up_sync   <= 3'b000;
    end else begin
      mode_sync <= {mode_sync[1:0], bus.btn_mode};
      up_sync   <= {up_sync[1:0], bus.btn_up};
    end
  end

  // Next-state, repeat engine, timeout and registered-output decode
  always_comb begin
    state_next   = state;
    sec_en_next  = 1'b0;
    min_en_next  = 1'b0;
    hour_en_next = 1'b0;
    sec_clr_next = 1'b0;
    phase_next   = phase_q;
    to_next      = to_cnt;
    hold_next    = '0;
    first_next   = 1'b0;
    rep_step     = 1'b0;
    blink_next   = 3'b000;

    // Auto-repeat only in the hour/min set modes; a mode press disarms it
    if ((state == SET_HOUR || state == SET_MIN) && !mode_rise) begin
      if (up_rise) begin
        hold_next  = CNT_ONE;
        first_next = 1'b1;
      end else if (up_lvl && hold_cnt != '0) begin
        if (hold_cnt == (rep_first ? DLY_V : PER_V)) begin
          rep_step  = 1'b1;
          hold_next = CNT_ONE;
        end else begin
          hold_next  = hold_cnt + CNT_ONE;
          first_next = rep_first;
        end
      end
    end

    // A mode press in the same cycle swallows any up step
    step = (up_rise | rep_step) & ~mode_rise;

    case (state)
      RUN: begin
        sec_en_next  = bus.tick_1hz;
        min_en_next  = bus.tick_1hz & bus.sec_tc;
        hour_en_next = bus.tick_1hz & bus.sec_tc & bus.min_tc;
        phase_next   = 1'b0;
        to_next      = '0;
        if (mode_rise) state_next = SET_HOUR;
      end
      default: begin
        if (mode_rise) begin
          case (state)
            SET_HOUR: state_next = SET_MIN;
            SET_MIN:  state_next = SET_SEC;
            default:  state_next = RUN;
          endcase
          phase_next = 1'b0;
          to_next    = '0;
        end else begin
          if (bus.tick_1hz) phase_next = ~phase_q;
          if (step) begin
            to_next      = '0;
            hour_en_next = (state == SET_HOUR);
            min_en_next  = (state == SET_MIN);
            sec_clr_next = (state == SET_SEC);
          end else if (bus.tick_1hz) begin
            if (to_cnt == TO_LAST) begin
              state_next = RUN;
              to_next    = '0;
              phase_next = 1'b0;
              hold_next  = '0;
              first_next = 1'b0;
            end else begin
              to_next = to_cnt + TO_ONE;
            end
          end
        end
      end
    endcase

    case (state_next)
      SET_HOUR: blink_next = 3'b100;
      SET_MIN:  blink_next = 3'b010;
      SET_SEC:  blink_next = 3'b001;
      default:  blink_next = 3'b000;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= RUN;
      hold_cnt  <= '0;
      rep_first <= 1'b0;
      to_cnt    <= '0;
      sec_en_q  <= 1'b0;
      min_en_q  <= 1'b0;
      hour_en_q <= 1'b0;
      sec_clr_q <= 1'b0;
      phase_q   <= 1'b0;
      blink_q   <= 3'b000;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      rep_first <= first_next;
      to_cnt    <= to_next;
      sec_en_q  <= sec_en_next;
      min_en_q  <= min_en_next;
      hour_en_q <= hour_en_next;
      sec_clr_q <= sec_clr_next;
      phase_q   <= phase_next;
      blink_q   <= blink_next;
    end
  end

  assign bus.sec_en      = sec_en_q;
  assign bus.min_en      = min_en_q;
  assign bus.hour_en     = hour_en_q;
  assign bus.sec_clr     = sec_clr_q;
  assign bus.mode        = state;
  assign bus.blink_sel   = blink_q;
  assign bus.blink_phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_set_ctrl
// Description : Self-checking bench for clock_set_ctrl: directed scenarios
//               plus a randomized stretch, all compared every cycle against
//               a behavioural model of the sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int DLY = 8;
  localparam int PER = 4;
  localparam int TMO = 3;

  logic clk = 1'b0;
  logic clr;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER),
    .TIMEOUT_S  (TMO),
    .CNT_W      (5)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode number, seconds-idle count, cycles held since press
  int       m_mode, m_to, m_t;
  bit       m_blink, m_armed;
  bit       m_se, m_me, m_he, m_sc;
  bit [2:0] hm, hu;   // raw button samples at edges e-1, e-2, e-3
  int       n_se, n_me, n_he, n_sc;

  function automatic logic [9:0] dut_out();
    return {bus.sec_en, bus.min_en, bus.hour_en, bus.sec_clr,
            bus.mode, bus.blink_sel, bus.blink_phase};
  endfunction

  function automatic logic [9:0] model_out();
    logic [2:0] fs;
    fs = (m_mode == 1) ? 3'b100 : (m_mode == 2) ? 3'b010 :
         (m_mode == 3) ? 3'b001 : 3'b000;
    return {m_se, m_me, m_he, m_sc, 2'(m_mode), fs, m_blink};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_to = 0; m_t = 0; m_blink = 0; m_armed = 0;
    m_se = 0; m_me = 0; m_he = 0; m_sc = 0;
    hm = 3'b000; hu = 3'b000;
  endtask

  // One clock edge of the model, using the inputs presented before the edge
  task automatic model_edge(input bit t, input bit bm, input bit bu, input bit st, input bit mt);
    bit mp, up_press, up_lvl, stp;
    mp       = hm[1] & ~hm[2];
    up_lvl   = hu[1];
    up_press = hu[1] & ~hu[2];
    m_se = 0; m_me = 0; m_he = 0; m_sc = 0;
    if (m_mode == 0) begin
      m_se = t; m_me = t & st; m_he = t & st & mt;
      m_blink = 0; m_to = 0;
      if (mp) m_mode = 1;
    end else if (mp) begin
      m_mode = (m_mode + 1) % 4; m_to = 0; m_blink = 0; m_armed = 0;
    end else begin
      stp = 0;
      if (m_mode != 3) begin
        if (up_press) begin
          m_armed = 1; m_t = 0; stp = 1;
        end else if (m_armed && up_lvl) begin
          m_t++;
          stp = (m_t == DLY) || (m_t > DLY && ((m_t - DLY) % PER) == 0);
        end else if (!up_lvl) begin
          m_armed = 0;
        end
      end else begin
        stp = up_press;
      end
      if (t) m_blink = ~m_blink;
      if (stp) begin
        m_to = 0;
        m_he = (m_mode == 1); m_me = (m_mode == 2); m_sc = (m_mode == 3);
      end else if (t) begin
        m_to++;
        if (m_to == TMO) begin m_mode = 0; m_to = 0; m_blink = 0; end
      end
    end
    if (m_mode == 0) m_armed = 0;
    hm = {hm[1:0], bm};
    hu = {hu[1:0], bu};
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, step the model, then compare all outputs
  task automatic cyc(input bit t = 0, input bit bm = 0, input bit bu = 0,
                     input bit st = 0, input bit mt = 0);
    logic [9:0] got, exp;
    bus.tick_1hz = t; bus.btn_mode = bm; bus.btn_up = bu;
    bus.sec_tc = st; bus.min_tc = mt;
    @(posedge clk);
    model_edge(t, bm, bu, st, mt);
    #1;
    got = dut_out();
    exp = model_out();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs got=%b exp=%b t=%0t", got, exp, $time);
    end
    n_se += int'(bus.sec_en); n_me += int'(bus.min_en);
    n_he += int'(bus.hour_en); n_sc += int'(bus.sec_clr);
  endtask

  // Mode press; the event lands on the third cycle, optionally with a tick
  task automatic press_mode(input bit tick_on_event = 0);
    cyc(0, 1); cyc(0, 1); cyc(tick_on_event, 1); cyc(0, 1);
    cyc(); cyc(); cyc();
  endtask

  task automatic clear_counts();
    n_se = 0; n_me = 0; n_he = 0; n_sc = 0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.sec_tc = 0; bus.min_tc = 0;
    model_reset();
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  int  exp_m [4] = '{1, 2, 3, 0};
  int  exp_b [4] = '{4, 2, 1, 0};
  bit  rbm, rbu;

  initial begin
    clear_counts();
    clr = 1'b1;
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.sec_tc = 0; bus.min_tc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(dut_out()), 0);
    clr = 1'b0;

    // RUN cascade
    cyc(1, 0, 0, 1, 1);
    chk("cascade_all", int'({bus.sec_en, bus.min_en, bus.hour_en}), 7);
    cyc();
    chk("cascade_one_cycle", int'({bus.sec_en, bus.min_en, bus.hour_en}), 0);
    cyc(1, 0, 0, 0, 1);
    chk("tick_sec_only", int'({bus.sec_en, bus.min_en, bus.hour_en}), 4);
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1); cyc(); cyc(); cyc();

    // Mode cycling
    for (int i = 0; i < 4; i++) begin
      press_mode();
      chk("mode_cycle", int'(bus.mode), exp_m[i]);
      chk("blink_sel_cycle", int'(bus.blink_sel), exp_b[i]);
    end

    // Auto-repeat in SET_MIN, then single step in SET_SEC
    press_mode(); press_mode();
    clear_counts();
    repeat (18) cyc(0, 0, 1);
    repeat (6) cyc();
    chk("repeat_min_pulses", n_me, 4);
    chk("repeat_no_hour", n_he, 0);
    press_mode();
    clear_counts();
    repeat (18) cyc(0, 0, 1);
    repeat (6) cyc();
    chk("sec_clr_single", n_sc, 1);
    press_mode();
    chk("back_to_run", int'(bus.mode), 0);

    // Idle timeout
    press_mode();
    cyc(1); cyc(); cyc(1); cyc();
    chk("timeout_before", int'(bus.mode), 1);
    cyc(1);
    chk("timeout_mode", int'(bus.mode), 0);
    chk("timeout_blink", int'(bus.blink_phase), 0);
    press_mode();
    cyc(1); cyc(); cyc(1); cyc();
    clear_counts();
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1); cyc(); cyc(); cyc();
    chk("timeout_up_step", n_he, 1);
    cyc(1); cyc(); cyc(1); cyc();
    chk("timeout_tick4", int'(bus.mode), 1);
    cyc(1);
    chk("timeout_tick5", int'(bus.mode), 0);

    // Collisions
    press_mode();
    clear_counts();
    repeat (4) cyc(0, 1, 1);
    repeat (3) cyc();
    chk("collide_mode", int'(bus.mode), 2);
    chk("collide_no_hour", n_he, 0);
    press_mode(); press_mode(); press_mode();
    cyc(1);
    chk("set_tick_no_sec", int'(bus.sec_en), 0);
    chk("set_tick_blink", int'(bus.blink_phase), 1);
    press_mode(); press_mode();
    press_mode(1);
    chk("exit_tick_mode", int'(bus.mode), 0);
    clear_counts();
    cyc(); cyc(); cyc();
    chk("exit_tick_no_sec", n_se, 0);
    cyc(1);
    chk("exit_next_tick", int'(bus.sec_en), 1);

    // Randomized stretch
    rbm = 0; rbu = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) rbm = ~rbm;
      if ($urandom_range(0, 13) == 0) rbu = ~rbu;
      cyc(($urandom_range(0, 15) == 0), rbm, rbu,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an auto-repeat
    do_reset();
    press_mode(); press_mode();
    repeat (11) cyc(0, 0, 1);
    chk("pre_reset_min_en", int'(bus.min_en), 1);
    clr = 1'b1;
    bus.btn_up = 0;
    #1;
    chk("async_reset_outputs", int'(dut_out()), 0);
    model_reset();
    @(posedge clk); #1;
    clr = 1'b0;
    cyc(1, 0, 0, 0, 0);
    chk("post_reset_tick", int'({bus.sec_en, bus.min_en, bus.hour_en}), 4);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Sequencer for the digital-clock datapath: owns the count enables of the seconds, minutes and hours counters.
- In RUN it converts the 1 Hz tick and terminal-count flags into cascaded enables.
- In the three SET modes it halts timekeeping and steps the selected field from a pushbutton, with auto-repeat.
- It provides field-blink control to the display mux and returns to RUN after an idle timeout.

Parameters:
REPEAT_DLY, 25000000, clk cycles btn_up must be held before the first auto-repeat step
REPEAT_PER, 5000000, clk cycles between subsequent auto-repeat steps
TIMEOUT_S, 10, idle tick_1hz pulses in a SET mode before forced return to RUN
CNT_W, 25, width of the hold/repeat counter (must hold max(REPEAT_DLY, REPEAT_PER))

Ports:
clk  in  1  system clock; all state on rising edge
clr  in  1  asynchronous active-high reset
tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk
btn_mode  in  1  debounced level, asynchronous to clk
btn_up  in  1  debounced level, asynchronous to clk
sec_tc  in  1  seconds counter currently at 59 (combinational from counter)
min_tc  in  1  minutes counter currently at 59
sec_en  out  1  one-cycle count enable, seconds counter
min_en  out  1  one-cycle count enable, minutes counter
hour_en  out  1  one-cycle count enable, hours counter
sec_clr  out  1  one-cycle synchronous clear request, seconds counter
mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
blink_sel  out  3  one-hot field being set {hour,min,sec}; 000 in RUN
blink_phase  out  1  display blank phase for the selected field

Behaviour:
- Reset (clr=1, async): mode=RUN; sec_en, min_en, hour_en, sec_clr = 0; blink_sel=000; blink_phase=0; all sync, hold and timeout registers = 0. Reset mid-press or mid-repeat aborts the press or repeat with no pulse.
- Inputs btn_mode and btn_up pass through a 2-flop synchroniser plus a rising-edge detect.
- Press latency: if a button is first sampled high at edge N, the press event is registered at edge N+2. Any resulting output pulse is high for exactly the one cycle after edge N+2.
- All outputs are registered.
- RUN:
  - sec_en = tick_1hz; min_en = tick_1hz & sec_tc; hour_en = tick_1hz & sec_tc & min_tc.
  - Each enable is registered, so it is high one cycle after the tick.
  - btn_up is ignored.
- FSM on mode press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
  - Entering any SET state clears the timeout counter and blink_phase.
- SET states:
  - tick_1hz does not advance time. Each tick toggles blink_phase and increments the timeout counter.
  - When the timeout counter reaches TIMEOUT_S, the FSM goes to RUN on that edge, with no enable pulse.
  - Any up press (including auto-repeat steps) clears the timeout counter.
  - SET_HOUR: up press gives one hour_en pulse.
  - SET_MIN: up press gives one min_en pulse only, with no carry to hour.
  - SET_SEC: up press gives one sec_clr pulse; there is no auto-repeat in this state.
- Auto-repeat (SET_HOUR, SET_MIN only):
  - The hold counter counts while the synchronised btn_up is high.
  - At REPEAT_DLY cycles after the press event, it emits a step and reloads; it then emits a step every REPEAT_PER cycles.
  - Release clears the counter immediately.
- blink_sel: 100 in SET_HOUR, 010 in SET_MIN, 001 in SET_SEC. blink_phase is forced 0 in RUN.
- Simultaneous events:
  - A mode press and an up press in the same cycle: mode wins and the up press is discarded.
  - A mode press while btn_up is held: the hold counter clears, and repeat restarts only after a fresh up press.
  - tick_1hz together with an up press in a SET state: both take effect (blink toggles and the step is emitted), and the timeout counter ends at 0.
  - A mode press leaving SET_SEC coincident with tick_1hz: the FSM enters RUN and that tick produces no sec_en. The first sec_en comes on the next tick.
- At most one of sec_en, min_en, hour_en, sec_clr is high in any SET-state cycle.

Test Plan:
- All tests use REPEAT_DLY=8, REPEAT_PER=4, TIMEOUT_S=3.
- RUN cascade: tick with sec_tc=1, min_tc=1 -> sec_en=min_en=hour_en=1 for exactly one cycle, one cycle after the tick. tick with sec_tc=0 -> sec_en only.
- Mode cycling: 4 mode presses -> mode 01,10,11,00 and blink_sel 100,010,001,000. Each change occurs 2 edges after the first high sample.
- Auto-repeat: in SET_MIN, hold btn_up for 20 cycles after the press event -> min_en at cycles 0, 8, 12, 16 (4 pulses), hour_en never asserted. In SET_SEC, the same hold -> exactly one sec_clr.
- Timeout: enter SET_HOUR, send 3 ticks with no press -> mode=00 on the 3rd tick edge and blink_phase=0. A press after tick 2 -> the count restarts and mode=00 only on tick 5.
- Collisions: mode and up presses rising in the same cycle in SET_HOUR -> mode=10 and no hour_en. tick during SET_HOUR -> no sec_en, blink_phase toggles.
- Reset: assert clr during auto-repeat in SET_MIN -> all outputs 0 immediately and mode=00. After release, tick with sec_tc=0 -> sec_en only.
